serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 95 +++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell consumes one operand bit per cycle, LSB first.
// Result appears WIDTH RUN cycles after start is accepted; done pulses for one cycle.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, psum;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_nx, last;

  // single full-adder cell
  assign s_bit = a_sh[0] ^ b_sh[0] ^ c;
  assign c_nx  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= a;
          b_sh <= b;
          psum <= '0;
          c    <= 1'b0;
          cnt  <= '0;
        end
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          psum <= {s_bit, psum[WIDTH-1:1]};
          c    <= c_nx;
          cnt  <= cnt + CW'(1);
          // final bit goes straight into the result so it is ready with done
          if (last) begin
            sum   <= {s_bit, psum[WIDTH-1:1]};
            carry <= c_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
